// File: rtl/prga_fifo_rr_drain_pkg.sv
// prga_fifo_rr_drain_pkg: shared state encoding and width helper for the round-robin drain
package prga_fifo_rr_drain_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prga_rr_pick.sv
// prga_rr_pick: rotating priority encoder, first requester at or after ptr
module prga_rr_pick
  import prga_fifo_rr_drain_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int ID_WIDTH = clog2_min1(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] pick,
  output logic                any_req
);
  logic [NUM_SRC-1:0]  rot;
  logic [ID_WIDTH-1:0] off;
  logic [ID_WIDTH:0]   sum;
  // rotate requests so ptr sits at bit 0, find lowest set bit, then undo the rotation modulo NUM_SRC
  always_comb begin
    rot = NUM_SRC'({req, req} >> ptr);
    off = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (rot[i]) off = ID_WIDTH'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    pick = (sum >= (ID_WIDTH+1)'(NUM_SRC)) ? ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_SRC)) : sum[ID_WIDTH-1:0];
    any_req = |req;
  end
endmodule

// File: rtl/prga_fifo_rr_drain.sv
// prga_fifo_rr_drain: round-robin drain of lookahead FIFOs into one lookahead read port
module prga_fifo_rr_drain
  import prga_fifo_rr_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC = 4,
  parameter int MAX_BURST = 4,
  localparam int ID_WIDTH = clog2_min1(NUM_SRC),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
  output logic [NUM_SRC-1:0]            src_rd,
  output logic                          empty,
  input  logic                          rd,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [ID_WIDTH-1:0]           dout_id
);
  state_t              state;
  logic [ID_WIDTH-1:0] grant, ptr, pick, nxt;
  logic [CW-1:0]       cnt;
  logic                any_req, in_grant, pop, last;
  prga_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (~src_empty),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );
  // zero-latency head view of the granted source; pops are blocked during reset
  always_comb begin
    in_grant = state == GRANT;
    empty = in_grant ? src_empty[grant] : 1'b1;
    dout = in_grant ? src_dout[grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    dout_id = in_grant ? grant : '0;
    pop = rd & ~empty & ~rst;
    src_rd = pop ? NUM_SRC'(1) << grant : '0;
    last = cnt == CW'(MAX_BURST - 1);
    nxt = (grant == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant + ID_WIDTH'(1);
  end
  // grant FSM: pick in IDLE, release on burst end or source empty, rotating ptr past the grantee
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        grant <= pick;
        cnt <= '0;
        state <= GRANT;
      end
    end else if ((pop && last) || src_empty[grant]) begin
      state <= IDLE;
      ptr <= nxt;
      cnt <= '0;
    end else if (pop) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_prga_fifo_rr_drain.sv
// tb_prga_fifo_rr_drain: scoreboard bench driving modelled lookahead FIFOs into the drain
module tb_prga_fifo_rr_drain;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int MB = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 1'b0;
  logic [NS-1:0] src_empty, src_rd;
  logic [NS*DW-1:0] src_dout;
  logic empty;
  logic [DW-1:0] dout;
  logic [IW-1:0] dout_id;
  logic [DW-1:0] fq[NS][$];
  logic [IW+DW-1:0] sb[$];
  int pc[$];
  int eg[$];
  int errs = 0;
  int checks = 0;
  int cy = 0;
  int npop = 0;
  int rdcnt[NS];
  logic s_empty;
  logic [DW-1:0] s_dout;
  logic [IW-1:0] s_id;
  logic [NS-1:0] s_rd;
  prga_fifo_rr_drain #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_empty (src_empty),
    .src_dout  (src_dout),
    .src_rd    (src_rd),
    .empty     (empty),
    .rd        (rd),
    .dout      (dout),
    .dout_id   (dout_id)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] word(input int s, input int j);
    return {s[3:0], j[3:0]};
  endfunction
  task automatic refresh();
    for (int i = 0; i < NS; i++) begin
      src_empty[i] = fq[i].size() == 0;
      src_dout[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask
  task automatic load(input int s, input int n);
    for (int j = 0; j < n; j++) fq[s].push_back(word(s, j));
    refresh();
  endtask
  task automatic expect_words(input int s, input int j0, input int n);
    for (int j = j0; j < j0 + n; j++) sb.push_back({IW'(s), word(s, j)});
  endtask
  task automatic cyc();
    logic [IW+DW-1:0] e;
    @(negedge clk);
    s_rd = src_rd;
    s_empty = empty;
    s_dout = dout;
    s_id = dout_id;
    check("rd_legal", ($countones(s_rd) <= 1) && ((s_rd & src_empty) == 0), 1);
    if (!rst && rd && !empty) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("dout", dout, e[DW-1:0]);
        check("dout_id", dout_id, e[DW +: IW]);
        check("src_rd", s_rd, NS'(1) << e[DW +: IW]);
      end
      pc.push_back(cy);
      npop++;
    end else check("src_rd_idle", s_rd, 0);
    @(posedge clk);
    #1;
    cy++;
    for (int i = 0; i < NS; i++)
      if (s_rd[i]) begin
        rdcnt[i]++;
        if (fq[i].size() > 0) void'(fq[i].pop_front());
      end
    refresh();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rd = 1'b0;
    for (int i = 0; i < NS; i++) begin
      fq[i].delete();
      rdcnt[i] = 0;
    end
    sb.delete();
    pc.delete();
    eg.delete();
    refresh();
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic run_pops(input int n);
    int lim = cy + 300;
    int tgt = npop + n;
    while (npop < tgt && cy < lim) cyc();
    check("pops_done", npop >= tgt, 1);
  endtask
  task automatic check_gaps(input string tag);
    check({tag, "_n"}, pc.size(), eg.size() + 1);
    for (int k = 0; k < eg.size() && k + 1 < pc.size(); k++) check(tag, pc[k+1] - pc[k], eg[k]);
  endtask
  initial begin
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("idle_empty", s_empty, 1);
      check("idle_rd", s_rd, 0);
      check("idle_id", s_id, 0);
      check("idle_dout", s_dout, 0);
    end
    do_reset();
    load(2, 6);
    expect_words(2, 0, 6);
    rd = 1'b1;
    run_pops(6);
    cyc();
    check("t2_empty_after", s_empty, 1);
    rd = 1'b0;
    eg = '{1, 1, 1, 2, 1};
    check_gaps("t2_gap");
    check("t2_rdcnt", rdcnt[2], 6);
    do_reset();
    for (int s = 0; s < NS; s++) load(s, 10);
    for (int g = 0; g < 5; g++) expect_words(g % NS, (g / NS) * MB, MB);
    rd = 1'b1;
    run_pops(20);
    rd = 1'b0;
    for (int k = 1; k < 20; k++) eg.push_back((k % MB == 0) ? 2 : 1);
    check_gaps("t3_gap");
    do_reset();
    load(1, 2);
    load(3, 5);
    expect_words(1, 0, 2);
    expect_words(3, 0, 5);
    rd = 1'b1;
    run_pops(7);
    rd = 1'b0;
    eg = '{1, 3, 1, 1, 1, 2};
    check_gaps("t4_gap");
    do_reset();
    load(0, 3);
    expect_words(0, 0, 3);
    for (int k = 0; k < 20 && src_rd == 0 && empty; k++) cyc();
    check("t5_ready", empty, 0);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    cyc();
    check("t5_hold1", s_dout, word(0, 1));
    cyc();
    check("t5_hold2", s_dout, word(0, 1));
    check("t5_hold_id", s_id, 0);
    rd = 1'b1;
    cyc();
    cyc();
    rd = 1'b0;
    check("t5_rdcnt", rdcnt[0], 3);
    check("t5_left", fq[0].size(), 0);
    do_reset();
    load(3, 4);
    expect_words(3, 0, 1);
    rd = 1'b1;
    run_pops(1);
    load(0, 2);
    rst = 1'b1;
    cyc();
    check("t6_rst_rd", s_rd, 0);
    rst = 1'b0;
    cyc();
    check("t6_idle_empty", s_empty, 1);
    check("t6_idle_id", s_id, 0);
    check("t6_kept", fq[3].size(), 3);
    expect_words(0, 0, 2);
    run_pops(2);
    rd = 1'b0;
    check("t6_src0_done", fq[0].size(), 0);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
